// File: rtl/mac_seq_ctrl.sv
// Purpose : sequences one dot-product job into CELL_N-wide chunks over fetch, multiply, accumulate and capture.
// Latency : per chunk 1 + MULT_LAT + 1 + ack + run + 1 + 1 cycles; vec_len=0 gives done one cycle after accept.
// Backpressure: start is taken only in IDLE and never queued; ACK_WAIT gives up after ACK_TO cycles and sets err.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start/vec_len/base_addr job request (operands sampled on the accepting edge)
//   rd_en/rd_addr/lane_en   operand fetch strobe, address and per-lane valid mask
//   mult_wen/acc_start      product gate and accumulation trigger (asserted together)
//   acc_finish/acc_out      accumulation engine status (1 = idle/done) and result
//   res_valid/res_data/res_idx  partial sum strobe, value and chunk index
//   busy/done/err           job status, end-of-job pulse, sticky handshake timeout
module mac_seq_ctrl #(
  parameter int CELL_N   = 16,
  parameter int D_LEN    = 32,
  parameter int LEN_W    = 13,
  parameter int ADDR_W   = 10,
  parameter int MULT_LAT = 4,
  parameter int ACK_TO   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [CELL_N-1:0] lane_en,
  output logic              mult_wen,
  output logic              acc_start,
  input  logic              acc_finish,
  input  logic [D_LEN-1:0]  acc_out,
  output logic              res_valid,
  output logic [D_LEN-1:0]  res_data,
  output logic [LEN_W-1:0]  res_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int MC_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam int AC_W = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
  // Wide enough for chunk_idx*CELL_N before it is folded into the address space.
  localparam int MW   = (LEN_W > ADDR_W) ? LEN_W : ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_MULT_WAIT, S_INJECT, S_ACK_WAIT,
    S_RUN_WAIT, S_CAPTURE, S_NEXT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  last_idx_q, last_idx_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  chunk_q, chunk_d;
  logic [MC_W-1:0]   mult_cnt_q, mult_cnt_d;
  logic [AC_W-1:0]   ack_cnt_q, ack_cnt_d;

  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CELL_N-1:0] lane_en_q, lane_en_d;
  logic              mult_wen_q, mult_wen_d;
  logic              acc_start_q, acc_start_d;
  logic              res_valid_q, res_valid_d;
  logic [D_LEN-1:0]  res_data_q, res_data_d;
  logic [LEN_W-1:0]  res_idx_q, res_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [CELL_N-1:0] lane_mask;
  logic              last_chunk;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    last_idx_d  = last_idx_q;
    rem_d       = rem_q;
    chunk_d     = chunk_q;
    mult_cnt_d  = mult_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    rd_addr_d   = rd_addr_q;
    lane_en_d   = lane_en_q;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    err_d       = err_q;
    lane_mask   = '0;
    last_chunk  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          // last_idx = ceil(vec_len/CELL_N) - 1; unused when vec_len is 0.
          last_idx_d = LEN_W'(((LEN_W+1)'(vec_len) + (LEN_W+1)'(CELL_N - 1))
                              / (LEN_W+1)'(CELL_N) - (LEN_W+1)'(1));
          rem_d      = LEN_W'(vec_len % LEN_W'(CELL_N));
          chunk_d    = '0;
          err_d      = 1'b0;
          state_d    = (vec_len == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        mult_cnt_d = '0;
        state_d    = S_MULT_WAIT;
      end
      S_MULT_WAIT: begin
        if (mult_cnt_q == MC_W'(MULT_LAT - 1)) begin
          state_d = S_INJECT;
        end else begin
          mult_cnt_d = mult_cnt_q + 1'b1;
        end
      end
      S_INJECT: begin
        ack_cnt_d = '0;
        state_d   = S_ACK_WAIT;
      end
      S_ACK_WAIT: begin
        // A low acc_finish on the very first cycle already counts as the ack.
        if (!acc_finish) begin
          state_d = S_RUN_WAIT;
        end else if (ack_cnt_q == AC_W'(ACK_TO - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      S_RUN_WAIT: begin
        // acc_out moves with the acc_finish rising edge, so it is taken on the
        // edge that enters CAPTURE and presented during CAPTURE.
        if (acc_finish) begin
          res_data_d = acc_out;
          res_idx_d  = chunk_q;
          state_d    = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (chunk_q == last_idx_q) begin
          state_d = S_DONE;
        end else begin
          chunk_d = chunk_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Fetch address and lane mask are set on entry to FETCH and then held.
    if (state_d == S_FETCH) begin
      last_chunk = (chunk_d == last_idx_d) && (rem_d != '0);
      for (int i = 0; i < CELL_N; i++) begin
        lane_mask[i] = !last_chunk || (LEN_W'(i) < rem_d);
      end
      lane_en_d = lane_mask;
      rd_addr_d = base_d + ADDR_W'(MW'(chunk_d) * MW'(CELL_N));
    end else if (state_d == S_IDLE) begin
      lane_en_d = '0;
    end

    rd_en_d     = (state_d == S_FETCH);
    mult_wen_d  = (state_d == S_INJECT);
    acc_start_d = (state_d == S_INJECT);
    res_valid_d = (state_d == S_CAPTURE);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      last_idx_q  <= '0;
      rem_q       <= '0;
      chunk_q     <= '0;
      mult_cnt_q  <= '0;
      ack_cnt_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      lane_en_q   <= '0;
      mult_wen_q  <= 1'b0;
      acc_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      last_idx_q  <= last_idx_d;
      rem_q       <= rem_d;
      chunk_q     <= chunk_d;
      mult_cnt_q  <= mult_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      lane_en_q   <= lane_en_d;
      mult_wen_q  <= mult_wen_d;
      acc_start_q <= acc_start_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign lane_en   = lane_en_q;
  assign mult_wen  = mult_wen_q;
  assign acc_start = acc_start_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_idx   = res_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
